// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the architectural PC, fetches 16-bit words over
// a req/ack memory handshake and hands each one to decode over valid/ready.
module fetch_unit #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic [15:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        stall,
    input  logic [15:0] next_pc,
    output logic [15:0] pc,
    output logic        halted,
    output logic        align_err,
    output logic [15:0] instr_count,
    output logic [1:0]  dbg_state
);

    // Handshakes:
    //   imem: imem_req is high for the whole FETCH state with imem_addr held at
    //         pc; a cycle with imem_req & imem_ack transfers imem_data.
    //   decode: instr_valid is high for the whole ISSUE state with instr held;
    //         a cycle with instr_valid & instr_ready & !stall retires instr.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        ISSUE  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic        align_err_q, align_err_d;
    logic [15:0] count_q, count_d;

    logic retire;
    logic is_halt;

    assign retire  = (state_q == ISSUE) && instr_ready && !stall;
    assign is_halt = (instr_q[15:12] == HALT_OPCODE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            instr_q     <= 16'h0000;
            align_err_q <= 1'b0;
            count_q     <= 16'h0000;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            align_err_q <= align_err_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        align_err_d = align_err_q;
        count_d     = count_q;

        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_data;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (retire) begin
                    // A retired halt freezes pc and the counter where they stand.
                    if (is_halt) begin
                        state_d = HALTED;
                    end else begin
                        pc_d    = {next_pc[15:1], 1'b0};
                        count_d = count_q + 16'd1;
                        state_d = FETCH;
                        if (next_pc[0]) begin
                            align_err_d = 1'b1;
                        end
                    end
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs come only from registers, so reset clears imem_req immediately.
    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = (state_q == ISSUE);
    assign pc          = pc_q;
    assign halted      = (state_q == HALTED);
    assign align_err   = align_err_q;
    assign instr_count = count_q;
    assign dbg_state   = state_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Owns the architectural PC register and fetches 16-bit instructions from instruction memory over a req/ack handshake.
- Presents each instruction to decode with a valid/ready handshake.
- Drives `pc` into the branch/PC-select stage, and on retirement loads that stage's selected next PC.
- Detects the halt opcode and counts retired instructions.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- HALT_OPCODE, 4'hF, value of instr[15:12] that halts the core.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  16  fetch address; equals pc while imem_req=1.
- imem_ack  in  1  memory returns imem_data this cycle.
- imem_data  in  16  instruction word; sampled only when imem_req & imem_ack.
- instr  out  16  captured instruction.
- instr_valid  out  1  instr is valid for decode.
- instr_ready  in  1  decode/execute retires instr this cycle.
- stall  in  1  blocks retirement while high.
- next_pc  in  16  next PC from PC-select stage; sampled at retirement.
- pc  out  16  current PC, fed to PC-select stage.
- halted  out  1  core halted.
- align_err  out  1  sticky: an odd next_pc was loaded.
- instr_count  out  16  retired-instruction counter.

Behaviour:
- Reset is asynchronous, active-high, single clock domain. While rst=1:
  - state=IDLE, pc=RESET_PC.
  - instr=0, instr_valid=0, imem_req=0, halted=0, align_err=0, instr_count=0.
- States: IDLE, FETCH, ISSUE, HALTED. All outputs are registered or decoded from state; no combinational path from inputs to outputs.
- IDLE: lasts one cycle after rst deasserts, then moves to FETCH.
- FETCH:
  - imem_req=1 and imem_addr=pc, both held stable until ack.
  - On imem_ack=1: instr<=imem_data, move to ISSUE.
  - Ack in the first FETCH cycle is legal; minimum fetch latency is 1 cycle.
  - Unbounded wait; no timeout.
- ISSUE:
  - instr_valid=1, imem_req=0.
  - Retirement happens when instr_ready=1 and stall=0.
  - On retirement with instr[15:12]==HALT_OPCODE: move to HALTED. pc and instr_count are unchanged.
  - On any other retirement:
    - pc<={next_pc[15:1],1'b0}.
    - If next_pc[0]=1, set align_err (sticky).
    - instr_count<=instr_count+1, wrapping 16'hFFFF->16'h0000.
    - Move to FETCH.
  - instr_ready with stall=1 does nothing; instr and instr_valid hold.
- HALTED:
  - halted=1, instr_valid=0, imem_req=0.
  - Terminal; only rst leaves it.
- imem_ack outside FETCH is ignored, and imem_data is not sampled.
- stall has no effect outside ISSUE.
- instr_ready outside ISSUE is ignored.
- pc changes only at retirement or reset, so the PC-select stage sees a stable pc for the whole fetch/issue.
- Reset mid-fetch: imem_req drops immediately. An ack arriving after rst deasserts, while in IDLE, is ignored.
- Throughput: at most one retirement per 2 cycles (FETCH + ISSUE minimum).

Test Plan:
- Reset with RESET_PC=16'h0000, ack immediately each fetch with data 16'h1234, instr_ready=1, next_pc=pc+2. Required response:
  - imem_addr sequence is 0000, 0002, 0004.
  - instr_count reaches 3 after 3 retirements.
  - Retirements occur every 2 cycles.
- Delay imem_ack 5 cycles. Required response:
  - imem_req and imem_addr are held stable for all 5 cycles.
  - instr_valid stays 0 until the cycle after ack.
  - Spurious imem_ack pulses during ISSUE do not change instr.
- In ISSUE with instr=16'h2000, stall=1 and instr_ready=1 for 4 cycles, then stall=0 with next_pc=16'h0040. Required response:
  - pc holds through the stall.
  - pc becomes 16'h0040 one cycle after stall drops.
  - instr_count increments exactly once.
- Fetch 16'hF000 with instr_ready=1. Required response:
  - halted=1 and pc unchanged.
  - instr_count not incremented.
  - imem_req stays 0 for 20 cycles.
  - Asserting rst returns to fetching RESET_PC.
- Retire with next_pc=16'h0033. Required response:
  - pc=16'h0032.
  - align_err=1, remaining 1 after later aligned branches until rst.
- Preload instr_count=16'hFFFF (force), retire once, expect 16'h0000. Separately, assert rst while imem_req=1. Required response:
  - imem_req falls without a clock edge.
  - A late ack is ignored.
  - The post-reset fetch address is RESET_PC.
